// File: rtl/brent_kung_pipe_adder.sv
// rtl/brent_kung_pipe_adder.sv - pipelined Brent-Kung prefix adder with valid/ready flow control
module brent_kung_pipe_adder #(
   parameter int WIDTH  = 12,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // Node 0 is the carry-in (position -1); node i+1 is operand bit i.
   // After the full network, node i holds the carry into bit i.
   localparam int N   = WIDTH + 1;
   localparam int LOG = $clog2(N);
   localparam int NL  = 2 * LOG - 1;

   // Apply prefix levels [lo, hi) of the up-sweep/down-sweep network to {G,P}.
   function automatic logic [2*N-1:0] prefix_levels(input logic [N-1:0] g_in,
                                                     input logic [N-1:0] p_in,
                                                     input int lo,
                                                     input int hi);
      logic [N-1:0] g, p, gn, pn;
      g = g_in;
      p = p_in;
      for (int d = 0; d < LOG; d++) begin
         if (d >= lo && d < hi) begin
            gn = g;
            pn = p;
            for (int i = 0; i < N; i++) begin
               if ((i + 1) % (2 << d) == 0) begin
                  gn[i] = g[i] | (p[i] & g[i-(1<<d)]);
                  pn[i] = p[i] & p[i-(1<<d)];
               end
            end
            g = gn;
            p = pn;
         end
      end
      for (int d = LOG - 2; d >= 0; d--) begin
         if ((2*LOG-2-d) >= lo && (2*LOG-2-d) < hi) begin
            gn = g;
            pn = p;
            for (int i = 0; i < N; i++) begin
               if (((i + 1) % (2 << d) == (1 << d)) && (i >= (2 << d))) begin
                  gn[i] = g[i] | (p[i] & g[i-(1<<d)]);
                  pn[i] = p[i] & p[i-(1<<d)];
               end
            end
            g = gn;
            p = pn;
         end
      end
      return {g, p};
   endfunction

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] vin;
   logic [STAGES-1:0] en;

   logic [N-1:0]     st_g  [STAGES];
   logic [N-1:0]     st_p  [STAGES];
   logic [WIDTH-1:0] st_pb [STAGES];

   // Load enables: a stage loads when empty or when its content moves on this cycle.
   always_comb begin
      logic chain;
      en    = '0;
      vin   = '0;
      chain = out_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         en[s] = ~v[s] | chain;
         chain = en[s];
      end
      vin[0] = in_valid;
      for (int s = 1; s < STAGES; s++) begin
         vin[s] = v[s-1];
      end
   end

   assign in_ready  = ~rst & en[0];
   assign out_valid = v[STAGES-1];

   // Per-stage valid bits; a bubble is overwritten as soon as upstream has data.
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (en[s]) v[s] <= vin[s];
         end
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = (NL * s) / STAGES;
      localparam int HI = (NL * (s + 1)) / STAGES;

      logic [2*N-1:0] gp_out;

      if (s == 0) begin : g_first
         assign st_g[0]  = {a & b, cin};
         assign st_p[0]  = {a ^ b, 1'b0};
         assign st_pb[0] = a ^ b;
      end

      assign gp_out = prefix_levels(st_g[s], st_p[s], LO, HI);

      if (s < STAGES - 1) begin : g_mid
         logic [N-1:0]     g_r, p_r;
         logic [WIDTH-1:0] pb_r;

         // Capture partially combined group signals for the next stage.
         always_ff @(posedge clk) begin
            if (rst) begin
               g_r  <= '0;
               p_r  <= '0;
               pb_r <= '0;
            end else if (en[s] && vin[s]) begin
               g_r  <= gp_out[2*N-1:N];
               p_r  <= gp_out[N-1:0];
               pb_r <= st_pb[s];
            end
         end

         assign st_g[s+1]  = g_r;
         assign st_p[s+1]  = p_r;
         assign st_pb[s+1] = pb_r;
      end else begin : g_last
         logic [N-1:0] carry;
         logic         unused_p;

         assign carry    = gp_out[2*N-1:N];
         assign unused_p = ^gp_out[N-1:0];

         // Final stage registers the result; held while the consumer stalls.
         always_ff @(posedge clk) begin
            if (rst) begin
               sum  <= '0;
               cout <= 1'b0;
               ovf  <= 1'b0;
            end else if (en[s] && vin[s]) begin
               sum  <= st_pb[s] ^ carry[WIDTH-1:0];
               cout <= carry[WIDTH];
               ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// tb/tb_brent_kung_pipe_adder.sv - self-checking bench for brent_kung_pipe_adder
module tb_brent_kung_pipe_adder;

   logic        clk;
   logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
   logic [11:0] a, b, sum;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int acc_cnt  = 0;

   logic [13:0] q[$];

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic        cin;
      logic [11:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   brent_kung_pipe_adder #(.WIDTH(12), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic logic [13:0] model12(input logic [11:0] x, input logic [11:0] y, input logic c);
      logic [12:0] f;
      logic        o;
      f = {1'b0, x} + {1'b0, y} + 13'(c);
      o = (x[11] == y[11]) && (f[11] != x[11]);
      return {o, f[12], f[11:0]};
   endfunction

   task automatic step(input logic iv, input logic [11:0] ia, input logic [11:0] ib,
                       input logic ic, input logic ordy);
      logic [13:0] e;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'(0));
         end else begin
            e = q.pop_front();
            chk("sb_result", 64'({ovf, cout, sum}), 64'(e));
         end
      end
      if (iv && in_ready) begin
         q.push_back(model12(ia, ib, ic));
         acc_cnt++;
      end
   endtask

   initial begin
      vec_t        tab[10];
      logic [9:0]  hist;
      logic [13:0] held;
      int          acc0;

      tab[0] = '{12'hFFF, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0};
      tab[1] = '{12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1};
      tab[2] = '{12'h800, 12'h800, 1'b0, 12'h000, 1'b1, 1'b1};
      tab[3] = '{12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b0};
      tab[4] = '{12'h555, 12'hAAA, 1'b0, 12'hFFF, 1'b0, 1'b0};
      tab[5] = '{12'h555, 12'hAAA, 1'b1, 12'h000, 1'b1, 1'b0};
      tab[6] = '{12'h123, 12'h456, 1'b1, 12'h57A, 1'b0, 1'b0};
      tab[7] = '{12'h800, 12'h7FF, 1'b1, 12'h000, 1'b1, 1'b0};
      tab[8] = '{12'h400, 12'h400, 1'b0, 12'h800, 1'b0, 1'b1};
      tab[9] = '{12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_out_valid", 64'(out_valid), 64'(0));
      chk("post_rst_result", 64'({ovf, cout, sum}), 64'(0));
      chk("post_rst_in_ready", 64'(in_ready), 64'(1));

      // single beats with exact latency
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = tab[i].a; b = tab[i].b; cin = tab[i].cin; out_ready = 1'b1;
         #1;
         chk("tab_in_ready", 64'(in_ready), 64'(1));
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         chk("tab_early_valid", 64'(out_valid), 64'(0));
         @(negedge clk);
         #1;
         chk("tab_out_valid", 64'(out_valid), 64'(1));
         chk("tab_sum", 64'(sum), 64'(tab[i].s));
         chk("tab_cout", 64'(cout), 64'(tab[i].co));
         chk("tab_ovf", 64'(ovf), 64'(tab[i].ov));
      end

      // back-to-back stream
      for (int i = 0; i < 10; i++) begin
         logic [11:0] ia;
         ia = 12'(i);
         step(i < 8, ia, 12'(3 * i), ia[0], 1'b1);
         hist[i] = out_valid;
      end
      chk("stream_valid_pattern", 64'(hist), 64'(10'b1111111100));
      chk("stream_drained", 64'(q.size()), 64'(0));

      // stall with full pipeline
      acc0 = acc_cnt;
      step(1'b1, 12'h0A5, 12'h15A, 1'b1, 1'b0);
      step(1'b1, 12'h7FF, 12'h7FF, 1'b1, 1'b0);
      step(1'b1, 12'h001, 12'h001, 1'b0, 1'b0);
      chk("stall_accepted", 64'(acc_cnt - acc0), 64'(2));
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      held = {ovf, cout, sum};
      repeat (5) begin
         step(1'b1, 12'h001, 12'h001, 1'b0, 1'b0);
         chk("hold_in_ready", 64'(in_ready), 64'(0));
         chk("hold_out_valid", 64'(out_valid), 64'(1));
         chk("hold_result", 64'({ovf, cout, sum}), 64'(held));
      end
      repeat (3) step(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
      chk("stall_drained", 64'(q.size()), 64'(0));
      chk("stall_in_ready_after", 64'(in_ready), 64'(1));

      // reset with two beats in flight
      step(1'b1, 12'h111, 12'h222, 1'b0, 1'b0);
      step(1'b1, 12'h333, 12'h444, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; a = 12'hABC; b = 12'h001; out_ready = 1'b0;
      #1;
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      q.delete();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_result", 64'({ovf, cout, sum}), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      repeat (5) begin
         step(1'b0, 12'h000, 12'h000, 1'b0, 1'b1);
         chk("midrst_no_stale", 64'(out_valid), 64'(0));
      end

      for (int t = 0; t < 20000 && done_cnt < 8; t++) @(negedge clk);
      chk("random_done", 64'(done_cnt), 64'(8));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_rand
      localparam int RW  = (gi / 2 == 0) ? 2 : (gi / 2 == 1) ? 12 : (gi / 2 == 2) ? 33 : 64;
      localparam int RS  = (gi % 2 == 1) ? $clog2(RW) + 1 : 1;
      localparam int RW1 = RW + 1;

      logic          r_rst, r_iv, r_ir, r_ov, r_or, r_cin, r_cout, r_ovf;
      logic [RW-1:0] r_a, r_b, r_sum;
      logic [RW+1:0] rq[$];

      brent_kung_pipe_adder #(.WIDTH(RW), .STAGES(RS)) u_rdut (
         .clk(clk), .rst(r_rst), .in_valid(r_iv), .in_ready(r_ir),
         .a(r_a), .b(r_b), .cin(r_cin), .out_valid(r_ov), .out_ready(r_or),
         .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
      );

      initial begin
         logic [RW:0]   full;
         logic [RW+1:0] e;
         int            n_acc, n_out;
         n_acc = 0;
         n_out = 0;
         r_rst = 1'b1; r_iv = 1'b0; r_or = 1'b0; r_a = '0; r_b = '0; r_cin = 1'b0;
         repeat (2) @(negedge clk);
         r_rst = 1'b0;
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            r_iv  = ($urandom_range(0, 3) != 0) && (c < 560);
            r_or  = (c >= 560) || ($urandom_range(0, 2) != 0);
            r_a   = RW'({$urandom(), $urandom()});
            r_b   = RW'({$urandom(), $urandom()});
            r_cin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
               r_a = '1;
               r_b = '1;
            end
            #1;
            if (r_ov && r_or) begin
               n_out++;
               if (rq.size() == 0) begin
                  chk("rand_unexpected", 64'(r_ov), 64'(0));
               end else begin
                  e = rq.pop_front();
                  chk("rand_sum", 64'(r_sum), 64'(e[RW-1:0]));
                  chk("rand_cout_ovf", 64'({r_cout, r_ovf}), 64'({e[RW], e[RW+1]}));
               end
            end
            if (r_iv && r_ir) begin
               n_acc++;
               full = {1'b0, r_a} + {1'b0, r_b} + RW1'(r_cin);
               e = {(r_a[RW-1] == r_b[RW-1]) && (full[RW-1] != r_a[RW-1]), full[RW], full[RW-1:0]};
               rq.push_back(e);
            end
         end
         chk("rand_count", 64'(n_out), 64'(n_acc));
         done_cnt++;
      end
   end

endmodule
